// File: rtl/hangman_control.sv
// Control FSM for a two-player hangman game: word entry, timed guesses,
// miss drawing and win/score bookkeeping. Outputs are registered decodes.
module hangman_control #(
  parameter int MAX_LEN  = 16,
  parameter int MAX_MISS = 9
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       go,
  input  logic       done_entry,
  input  logic       match,
  input  logic [4:0] remain,
  input  logic       draw_done,
  input  logic       timeout,
  output logic       clr_dp,
  output logic       ld_char,
  output logic       start_cmp,
  output logic       draw,
  output logic       time_en,
  output logic       time_rst,
  output logic       p1_win,
  output logic       p2_win,
  output logic [4:0] wordcount,
  output logic [3:0] misses,
  output logic [3:0] p1score,
  output logic [3:0] p2score,
  output logic [2:0] state
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ENTER   = 3'd1;
  localparam logic [2:0] GUESS   = 3'd2;
  localparam logic [2:0] COMPARE = 3'd3;
  localparam logic [2:0] DRAW    = 3'd4;
  localparam logic [2:0] CHECK   = 3'd5;
  localparam logic [2:0] P1WIN   = 3'd6;
  localparam logic [2:0] P2WIN   = 3'd7;

  localparam logic [4:0] LEN_LIM  = 5'(MAX_LEN);
  localparam logic [3:0] MISS_LIM = 4'(MAX_MISS);

  logic       go_q;
  logic       go_rise;
  logic [2:0] next;
  logic       load;

  assign go_rise = go & ~go_q;

  always_comb begin
    next = state;
    load = 1'b0;
    case (state)
      IDLE:    if (go_rise) next = ENTER;
      ENTER: begin
        // finishing the word wins over a simultaneous letter load
        if (done_entry && wordcount != 5'd0) next = GUESS;
        else if (go_rise && wordcount < LEN_LIM) load = 1'b1;
      end
      GUESS: begin
        if (go_rise)      next = COMPARE;
        else if (timeout) next = DRAW;
      end
      COMPARE: next = match ? CHECK : DRAW;
      DRAW:    if (draw_done) next = CHECK;
      CHECK: begin
        if (remain == 5'd0)        next = P2WIN;
        else if (misses >= MISS_LIM) next = P1WIN;
        else                       next = GUESS;
      end
      P1WIN:   if (go_rise) next = IDLE;
      P2WIN:   if (go_rise) next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      go_q      <= 1'b1;
      wordcount <= '0;
      misses    <= '0;
      p1score   <= '0;
      p2score   <= '0;
      ld_char   <= 1'b0;
      time_rst  <= 1'b0;
      clr_dp    <= 1'b1;
      start_cmp <= 1'b0;
      draw      <= 1'b0;
      time_en   <= 1'b0;
      p1_win    <= 1'b0;
      p2_win    <= 1'b0;
    end else begin
      state    <= next;
      go_q     <= go;
      ld_char  <= load;
      time_rst <= (next == GUESS) && (state != GUESS);

      if (state == IDLE)  wordcount <= '0;
      else if (load)      wordcount <= wordcount + 5'd1;

      if (state == IDLE) misses <= '0;
      else if (state == DRAW && draw_done && misses != 4'd15) misses <= misses + 4'd1;

      if (next == P1WIN && state != P1WIN && p1score != 4'd15) p1score <= p1score + 4'd1;
      if (next == P2WIN && state != P2WIN && p2score != 4'd15) p2score <= p2score + 4'd1;

      // decode the upcoming state so outputs line up with the state register
      clr_dp    <= (next == IDLE);
      start_cmp <= (next == COMPARE);
      draw      <= (next == DRAW);
      time_en   <= (next == GUESS);
      p1_win    <= (next == P1WIN);
      p2_win    <= (next == P2WIN);
    end
  end

endmodule

// File: doc/hangman_control.md
HANGMAN_CONTROL -- requirements
Module: hangman_control

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, maximum secret-word letters (1..31).
REQ-002 SHALL have parameter MAX_MISS, default 9, hangman parts drawn before player 1 wins (1..15).
REQ-003 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port go  input  1  level pushbutton; used only through its rising edge.
REQ-006 SHALL have port done_entry  input  1  player 1 ends word entry.
REQ-007 SHALL have port match  input  1  datapath compare result, sampled in COMPARE only.
REQ-008 SHALL have port remain  input  5  count of unfilled letters from the datapath.
REQ-009 SHALL have port draw_done  input  1  datapath has finished drawing the current part.
REQ-010 SHALL have port timeout  input  1  guess timer expired.
REQ-011 SHALL have outputs clr_dp, ld_char, start_cmp, draw, time_en, time_rst, p1_win and p2_win, each 1 bit, as defined under Function.
REQ-012 SHALL have outputs wordcount (5 bits: letters loaded), misses (4 bits: parts drawn), p1score and p2score (4 bits each) and state (3 bits: encoding in REQ-014).

Function
REQ-013 SHALL register go into go_q every cycle and define go_rise = go AND NOT go_q.
REQ-014 SHALL implement states IDLE=0, ENTER=1, GUESS=2, COMPARE=3, DRAW=4, CHECK=5, P1WIN=6, P2WIN=7, with state output equal to the current encoding.
REQ-015 SHALL apply these IDLE rules: clr_dp=1, wordcount and misses cleared, go_rise -> ENTER.
REQ-016 SHALL apply these ENTER rules: done_entry with wordcount!=0 -> GUESS; else go_rise with wordcount<MAX_LEN pulses ld_char for 1 cycle and increments wordcount.
REQ-017 SHALL ignore done_entry in ENTER while wordcount=0, and SHALL ignore go_rise at wordcount=MAX_LEN (saturate, no ld_char).
REQ-018 SHALL give done_entry priority over go_rise in the same ENTER cycle: no ld_char, go to GUESS.
REQ-019 SHALL pulse time_rst for exactly the first cycle of every entry into GUESS.
REQ-020 SHALL apply these GUESS rules: time_en=1; go_rise -> COMPARE; otherwise timeout -> DRAW (counts as a miss); go_rise beats a simultaneous timeout.
REQ-021 SHALL apply these COMPARE rules: 1 cycle with start_cmp=1, then match=1 -> CHECK and match=0 -> DRAW.
REQ-022 SHALL apply these DRAW rules: draw held at 1 until draw_done; on draw_done, misses increments (saturating at 15) and the next state is CHECK.
REQ-023 SHALL apply these CHECK rules: 1 cycle, then remain=0 -> P2WIN, else misses>=MAX_MISS -> P1WIN, else GUESS; remain=0 beats the miss limit.
REQ-024 SHALL increment p2score (P2WIN) or p1score (P1WIN) once on state entry, saturating at 15.
REQ-025 SHALL hold p1_win=1 throughout P1WIN and p2_win=1 throughout P2WIN, with go_rise -> IDLE from either.
REQ-026 SHALL clear p1score and p2score only on reset, so scores persist across rounds.
REQ-027 SHALL drive all control outputs as registered Moore decodes of state, except ld_char and time_rst, which are registered 1-cycle pulses.
REQ-028 SHALL keep all control outputs 0 in any state not listed for them.

Reset
REQ-029 SHALL, while resetn=0, force state=IDLE, all counters and scores to 0, all pulses to 0, and go_q=1, so a button held through reset release causes no go_rise.
REQ-030 SHALL, on reset asserted mid-round, abandon the round immediately (draw, time_en and ld_char drop asynchronously to 0).

Verification
REQ-031 SHALL cover full game (P2 win): go, 3 go pulses, done_entry -> wordcount=3; 3 guesses with match=1, remain 2,1,0 -> P2WIN, p2_win=1, p2score=1.
REQ-032 SHALL cover P1 win by misses: MAX_MISS=9, 9 guesses with match=0 and draw_done after 4 cycles each -> misses=9, P1WIN, p1score=1, draw high 4 cycles per miss.
REQ-033 SHALL cover entry boundaries: done_entry at wordcount=0 ignored; 17 go pulses -> wordcount=16 and exactly 16 ld_char pulses; done_entry with go_rise in the same cycle -> GUESS and no ld_char.
REQ-034 SHALL cover timeout: timeout in GUESS -> DRAW and misses+1; go_rise with timeout in the same cycle -> COMPARE; time_rst pulses on every GUESS entry.
REQ-035 SHALL cover reset: go held high across resetn release -> remain in IDLE; resetn low during DRAW -> draw=0 at once and state=0.
REQ-036 SHALL cover score saturation: 16 consecutive P2 wins -> p2score=15.
